// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the multicycle control FSM (master) and
// the datapath/memory side (slave).
interface multicycle_control_fsm_if #(
  parameter int INSTRET_W = 32
);
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 ir_write;
  logic                 adr_src;
  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write;
  logic [1:0]           result_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic [1:0]           imm_src;
  logic                 branch_taken;
  logic                 illegal_instr;
  logic [3:0]           state;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src,
           branch_taken, illegal_instr, state, instret
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src,
           branch_taken, illegal_instr, state, instret
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// memory, ALU and branch steps for lw/sw/beq/R-type; anything else traps.
module multicycle_control_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_TRAP     = 4'd9
  } state_t;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 retire_s;

  logic       pc_write_s, ir_write_s, adr_src_s, mem_read_s, mem_write_s;
  logic       reg_write_s, branch_taken_s;
  logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s, imm_src_s;

  // Next-state and retirement decode; unused encodings fall into TRAP.
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               state_d = S_FETCH;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_BR: begin
            if (bus.funct3 == 3'b000) state_d = S_BEQ;
            else                      state_d = S_TRAP;
          end
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_SW) state_d = S_MEMWRITE;
        else                     state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (bus.mem_ready) state_d = S_MEMWB;
        else               state_d = S_MEMREAD;
      end
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_MEMWRITE: begin
        if (bus.mem_ready) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_MEMWRITE;
        end
      end
      S_EXECR: state_d = S_ALUWB;
      S_ALUWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_BEQ: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Sticky trap flag and retirement counter (wraps naturally).
  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    if (retire_s) instret_d = instret_q + INSTRET_W'(1);
    else          instret_d = instret_q;
  end

  // State, trap flag and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Control outputs decoded from the registered state; handshake-dependent
  // enables in FETCH and BEQ follow mem_ready/zero in the same cycle.
  always_comb begin
    pc_write_s     = 1'b0;
    ir_write_s     = 1'b0;
    adr_src_s      = 1'b0;
    mem_read_s     = 1'b0;
    mem_write_s    = 1'b0;
    reg_write_s    = 1'b0;
    branch_taken_s = 1'b0;
    result_src_s   = 2'b00;
    alu_src_a_s    = 2'b00;
    alu_src_b_s    = 2'b00;
    alu_op_s       = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_s   = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = bus.mem_ready;
        pc_write_s   = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEMREAD: begin
        adr_src_s  = 1'b1;
        mem_read_s = 1'b1;
      end
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BEQ: begin
        alu_src_a_s    = 2'b10;
        alu_op_s       = 2'b01;
        pc_write_s     = bus.zero;
        branch_taken_s = bus.zero;
      end
      S_TRAP:  pc_write_s = 1'b0;
      default: pc_write_s = 1'b0;
    endcase
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    case (bus.opcode)
      OP_LW:   imm_src_s = 2'b00;
      OP_SW:   imm_src_s = 2'b01;
      OP_BR:   imm_src_s = 2'b10;
      default: imm_src_s = 2'b00;
    endcase
  end

  assign bus.pc_write      = pc_write_s;
  assign bus.ir_write      = ir_write_s;
  assign bus.adr_src       = adr_src_s;
  assign bus.mem_read      = mem_read_s;
  assign bus.mem_write     = mem_write_s;
  assign bus.reg_write     = reg_write_s;
  assign bus.result_src    = result_src_s;
  assign bus.alu_src_a     = alu_src_a_s;
  assign bus.alu_src_b     = alu_src_b_s;
  assign bus.alu_op        = alu_op_s;
  assign bus.imm_src       = imm_src_s;
  assign bus.branch_taken  = branch_taken_s;
  assign bus.illegal_instr = illegal_q;
  assign bus.state         = state_q;
  assign bus.instret       = instret_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle RV32I core.
- Sequences PC, instruction register, ALU operand muxes, register-file write and memory handshakes over several clocks per instruction.
- Drives the immediate-format select consumed by the immediate generator.
- Supports lw, sw, beq and R-type. Any other instruction traps.

Parameters:
INSTRET_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  PC load enable
ir_write  output  1  instruction register / oldPC load enable
adr_src  output  1  0 = PC, 1 = ALUOut drives memory address
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register-file write enable
result_src  output  2  00 ALUOut, 01 read data, 10 ALU result direct
alu_src_a  output  2  00 PC, 01 oldPC, 10 rs1
alu_src_b  output  2  00 rs2, 01 immediate, 10 constant 4
alu_op  output  2  00 add, 01 sub (compare), 10 decode funct
imm_src  output  2  00 I, 01 S, 10 B
branch_taken  output  1  beq resolved taken
illegal_instr  output  1  trap flag, sticky
state  output  4  current state, for debug
instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high and is sampled only on the rising edge of clk.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, BEQ=8, TRAP=9.
- Reset:
  - state=FETCH, instret=0, illegal_instr=0.
  - Reset overrides every transition, including TRAP and a mid-access wait.
  - Outputs take their FETCH values in the cycle after reset.
- imm_src: purely combinational from opcode in every state.
  - 0000011 -> 00, 0100011 -> 01, 1100011 -> 10, otherwise 00.
- Output defaults: every control output is 0 unless listed for the current state below.
- FETCH:
  - Outputs: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Transition: stay while !mem_ready, else go to DECODE.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - Transitions:
    - 0000011 or 0100011 -> MEMADR.
    - 0110011 -> EXECR.
    - 1100011 with funct3=000 -> BEQ.
    - Anything else -> TRAP.
- MEMADR:
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=00.
  - Transitions: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD:
  - Outputs: adr_src=1, mem_read=1.
  - Transition: wait for mem_ready, then MEMWB.
- MEMWB:
  - Outputs: result_src=01, reg_write=1.
  - Transition: -> FETCH.
- MEMWRITE:
  - Outputs: adr_src=1, mem_write=1.
  - mem_write stays high until the mem_ready cycle.
  - Transition: -> FETCH on mem_ready.
- EXECR:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=10.
  - Transition: -> ALUWB.
- ALUWB:
  - Outputs: result_src=00, reg_write=1.
  - Transition: -> FETCH.
- BEQ:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write=branch_taken=zero (Mealy).
  - Transition: -> FETCH.
- TRAP:
  - illegal_instr is set on entry and held.
  - All enables are 0. PC and memory are frozen.
  - Transition: stay until reset.
- Latency with mem_ready constantly 1: lw 5 cycles, sw 4, R-type 4, beq 3. Each cycle mem_ready is low during FETCH/MEMREAD/MEMWRITE adds one cycle.
- instret:
  - Increments by 1 on each retiring transition into FETCH: from MEMWB, from MEMWRITE&mem_ready, from ALUWB, from BEQ.
  - Wraps modulo 2^INSTRET_W.
  - Never increments in TRAP.
- mem_read and mem_write are never high in the same cycle.
- reg_write and pc_write are never high together.

Test Plan:
- lw (opcode 0000011) with mem_ready=1 -> states 0,1,2,3,4,0.
  - ir_write and pc_write high only in cycle 0.
  - reg_write with result_src=01 in cycle 4.
  - imm_src=00; instret 0->1.
- sw with mem_ready low for 3 cycles in FETCH and 2 in MEMWRITE -> 9 total cycles.
  - mem_write high 3 cycles.
  - imm_src=01; reg_write never asserted.
- beq, funct3=000: zero=1 -> BEQ cycle has pc_write=1, branch_taken=1. zero=0 -> pc_write=0.
  - imm_src=10 in both cases; 3 cycles each.
- R-type 0110011 -> alu_op=10 in EXECR, reg_write with result_src=00 in ALUWB.
  - Back-to-back lw, R, beq, sw gives instret=4.
- Opcode 1101111, or beq with funct3=001 -> TRAP, illegal_instr=1.
  - Holds there 20 cycles with all enables 0.
  - reset=1 for one cycle -> FETCH, illegal_instr=0, instret=0.
- Reset asserted during a MEMREAD wait -> FETCH next cycle, mem_read from PC (adr_src=0).
  - Preset instret to all-ones via 2^INSTRET_W-1 retirements (INSTRET_W=4 build) -> wraps to 0.
